// File: rtl/period_channel_arbiter.sv
// period_channel_arbiter: round-robin merge of per-channel period results into one tagged valid/ready stream
//   Build option: define PERIOD_ARB_OVERRUN_EN to add the OVERRUN/OVERRUN_CLR ports.
//   Ports:
//     CLK_PARALLEL  clock
//     RESET         synchronous, active-high
//     CE            clock enable; low freezes all state
//     OVERRUN_CLR   (option) clears OVERRUN sticky bits
//     OVERRUN       (option) sticky per-channel "pending sample overwritten" flags
//     CH_CHANGE     per-channel new-period strobe
//     CH_PERIOD     packed per-channel period values, channel k at [k*PERIOD_BITS +: PERIOD_BITS]
//     OUT_VALID/OUT_READY/OUT_CHANNEL/OUT_PERIOD  output stream
//     CH_TIMEOUT    per-channel no-signal flag
module period_channel_arbiter #(
    parameter int CHANNELS       = 2,
    parameter int PERIOD_BITS    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                              CLK_PARALLEL,
    input  logic                              RESET,
    input  logic                              CE,
`ifdef PERIOD_ARB_OVERRUN_EN
    input  logic                              OVERRUN_CLR,
    output logic [CHANNELS-1:0]               OVERRUN,
`endif
    input  logic [CHANNELS-1:0]               CH_CHANGE,
    input  logic [CHANNELS*PERIOD_BITS-1:0]   CH_PERIOD,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic [(CHANNELS>1 ? $clog2(CHANNELS) : 1)-1:0] OUT_CHANNEL,
    output logic [PERIOD_BITS-1:0]            OUT_PERIOD,
    output logic [CHANNELS-1:0]               CH_TIMEOUT
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    logic [CHANNELS-1:0]    pending;
    logic [PERIOD_BITS-1:0] hold_buf [CHANNELS];
    logic [TW-1:0]          cnt [CHANNELS];
    logic [CW-1:0]          rr_ptr;
    logic [CW-1:0]          grant;
    logic                   found;
    logic                   take;
    logic [CHANNELS-1:0]    gmask;
    // first pending channel at or after rr_ptr, wrapping
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && pending[(int'(rr_ptr) + i) % CHANNELS]) begin
                found = 1'b1;
                grant = CW'((int'(rr_ptr) + i) % CHANNELS);
            end
        end
    end
    assign take  = found && (!OUT_VALID || OUT_READY);
    assign gmask = take ? (CHANNELS'(1) << grant) : '0;
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET) begin
            OUT_VALID   <= 1'b0;
            OUT_CHANNEL <= '0;
            OUT_PERIOD  <= '0;
            rr_ptr      <= '0;
            pending     <= '0;
            CH_TIMEOUT  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                hold_buf[k] <= '0;
                cnt[k]      <= '0;
            end
        end else if (CE) begin
            if (!OUT_VALID || OUT_READY)
                OUT_VALID <= found;
            if (take) begin
                OUT_CHANNEL <= grant;
                OUT_PERIOD  <= hold_buf[grant];
                rr_ptr      <= CW'((int'(grant) + 1) % CHANNELS);
            end
            // a capture in the grant cycle keeps pending set: the grant took the old value
            pending <= (pending & ~gmask) | CH_CHANGE;
            for (int k = 0; k < CHANNELS; k++) begin
                if (CH_CHANGE[k]) begin
                    hold_buf[k]   <= CH_PERIOD[k*PERIOD_BITS +: PERIOD_BITS];
                    cnt[k]        <= '0;
                    CH_TIMEOUT[k] <= 1'b0;
                end else begin
                    cnt[k]        <= (cnt[k] == TMAX) ? TMAX : cnt[k] + TW'(1);
                    CH_TIMEOUT[k] <= (cnt[k] == TMAX);
                end
            end
        end
    end
`ifdef PERIOD_ARB_OVERRUN_EN
    // a new set event outranks a simultaneous clear
    always_ff @(posedge CLK_PARALLEL) begin
        if (RESET)
            OVERRUN <= '0;
        else if (CE)
            OVERRUN <= (OVERRUN_CLR ? '0 : OVERRUN) | (CH_CHANGE & pending & ~gmask);
    end
`endif
endmodule

// File: tb/tb_period_channel_arbiter.sv
// tb_period_channel_arbiter: directed table and sequence checks for period_channel_arbiter
module tb_period_channel_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic [1:0]  chg = '0;
    logic [31:0] per_in = '0;
    logic        valid;
    logic        rdy = 1'b1;
    logic        out_ch;
    logic [15:0] out_per;
    logic [1:0]  to;
`ifdef PERIOD_ARB_OVERRUN_EN
    logic        ov_clr = 1'b0;
    logic [1:0]  ov;
`endif
    int checks = 0;
    int errors = 0;

    period_channel_arbiter #(.CHANNELS(2), .PERIOD_BITS(16), .TIMEOUT_CYCLES(10)) dut (
        .CLK_PARALLEL(clk),
        .RESET(rst),
        .CE(ce),
`ifdef PERIOD_ARB_OVERRUN_EN
        .OVERRUN_CLR(ov_clr),
        .OVERRUN(ov),
`endif
        .CH_CHANGE(chg),
        .CH_PERIOD(per_in),
        .OUT_VALID(valid),
        .OUT_READY(rdy),
        .OUT_CHANNEL(out_ch),
        .OUT_PERIOD(out_per),
        .CH_TIMEOUT(to)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        r;
        logic [1:0]  c;
        logic [15:0] p0;
        logic [15:0] p1;
        logic        rd;
        logic        v;
        logic        ch;
        logic [15:0] per;
    } vec_t;
    vec_t tbl [18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b01, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h1234};
        tbl[2]  = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 2'b11, 16'h0100, 16'h0200, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0100};
        tbl[6]  = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0200};
        tbl[7]  = '{1'b0, 2'b01, 16'h0300, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 2'b11, 16'h0400, 16'h0500, 1'b1, 1'b1, 1'b0, 16'h0300};
        tbl[9]  = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0500};
        tbl[10] = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0400};
        tbl[11] = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[12] = '{1'b0, 2'b01, 16'h000A, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        tbl[13] = '{1'b0, 2'b01, 16'h000B, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h000A};
        tbl[14] = '{1'b0, 2'b01, 16'h000C, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h000A};
        tbl[15] = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h000A};
        tbl[16] = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h000C};
        tbl[17] = '{1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};

        step();
        step();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_channel", 32'(out_ch), 32'd0);
        chk("reset_period", 32'(out_per), 32'd0);
        chk("reset_timeout", 32'(to), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].r;
            chg = tbl[i].c;
            per_in = {tbl[i].p1, tbl[i].p0};
            rdy = tbl[i].rd;
            step();
            chk($sformatf("row%0d_valid", i), 32'(valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("row%0d_channel", i), 32'(out_ch), 32'(tbl[i].ch));
                chk($sformatf("row%0d_period", i), 32'(out_per), 32'(tbl[i].per));
            end
        end
        rst = 1'b0;
        chg = '0;

`ifdef PERIOD_ARB_OVERRUN_EN
        chk("overrun_set", 32'(ov), 32'd1);
        ov_clr = 1'b1;
        step();
        ov_clr = 1'b0;
        chk("overrun_clr", 32'(ov), 32'd0);
`endif

        // watchdog
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("wd_before", 32'(to), 32'd0);
        step();
        chk("wd_fire", 32'(to), 32'd3);
        chg = 2'b10;
        step();
        chg = '0;
        chk("wd_clear", 32'(to), 32'd1);
        repeat (10) step();
        chk("wd_restart_before", 32'(to), 32'd1);
        step();
        chk("wd_restart_fire", 32'(to), 32'd3);

        // reset while a word is presented and both channels pending
        rdy = 1'b0;
        chg = 2'b11;
        per_in = {16'h2222, 16'h1111};
        step();
        step();
        chk("pre_reset_valid", 32'(valid), 32'd1);
        rst = 1'b1;
        chg = '0;
        step();
        chk("mid_reset_valid", 32'(valid), 32'd0);
        chk("mid_reset_channel", 32'(out_ch), 32'd0);
        chk("mid_reset_period", 32'(out_per), 32'd0);
        chk("mid_reset_timeout", 32'(to), 32'd0);
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_reset_idle%0d", i), 32'(valid), 32'd0);
        end

        // clock enable freeze
        chg = 2'b01;
        per_in = {16'h0000, 16'h0777};
        step();
        chg = '0;
        step();
        chk("ce_pre_valid", 32'(valid), 32'd1);
        chk("ce_pre_period", 32'(out_per), 32'h0777);
        ce = 1'b0;
        chg = 2'b11;
        per_in = {16'h0999, 16'h0999};
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("ce_hold_valid%0d", i), 32'(valid), 32'd1);
            chk($sformatf("ce_hold_period%0d", i), 32'(out_per), 32'h0777);
            chk($sformatf("ce_hold_timeout%0d", i), 32'(to), 32'd0);
        end
        ce = 1'b1;
        chg = '0;
        step();
        chk("ce_resume_valid", 32'(valid), 32'd0);
        repeat (4) step();
        chk("ce_resume_to_before", 32'(to), 32'd0);
        step();
        chk("ce_resume_to_fire", 32'(to), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
